// File: rtl/maze_player_ctrl.sv
// Push-button player controller for the VGA maze renderer: synchronises buttons,
// steps the player tile by tile with wall/edge blocking, auto-repeat and win detection.
module maze_player_ctrl #(
  parameter int unsigned REPEAT_TICKS = 5_000_000,
  parameter int unsigned MAP_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         load,
  input  logic [255:0] path_data,
  input  logic [4:0]   maze_width,
  input  logic [4:0]   maze_height,
  input  logic [4:0]   start_x,
  input  logic [4:0]   start_y,
  input  logic [4:0]   exit_x,
  input  logic [4:0]   exit_y,
  input  logic [4:0]   view_w,
  input  logic [4:0]   view_h,
  output logic [6:0]   char_x,
  output logic [6:0]   char_y,
  output logic [4:0]   x_coord,
  output logic [4:0]   y_coord,
  output logic [15:0]  moves,
  output logic         won
);

  localparam int unsigned CNT_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, HOLD, WON} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DN, DIR_LT, DIR_RT} dir_t;

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d, pdir;
  logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         cx_q, cx_d, cy_q, cy_d;
  logic [4:0]         xc_q, xc_d, yc_q, yc_d;
  logic [15:0]        moves_q, moves_d;
  logic               won_q, won_d;

  logic               b_up, b_dn, b_lt, b_rt, any_btn;
  logic signed [6:0]  tx, ty;
  logic [4:0]         w_eff, h_eff;
  logic [7:0]         bit_idx;
  logic               blocked, hit_exit;

  // Scroll origin: centre the player, clamped so the view never leaves the maze.
  function automatic logic [4:0] scroll(input logic [4:0] c, input logic [4:0] sz,
                                        input logic [4:0] v);
    logic [4:0]        se;
    logic signed [7:0] d, mx;
    logic [4:0]        r;
    se = (sz > 5'd16) ? 5'd16 : sz;
    d  = $signed({3'b000, c}) - $signed({4'b0000, v[4:1]});
    mx = $signed({3'b000, se}) - $signed({3'b000, v});
    if (se <= v)      r = '0;
    else if (d < 0)   r = '0;
    else if (d > mx)  r = mx[4:0];
    else              r = d[4:0];
    return r;
  endfunction

  assign b_up    = sync2_q[0];
  assign b_dn    = sync2_q[1];
  assign b_lt    = sync2_q[2];
  assign b_rt    = sync2_q[3];
  assign any_btn = |sync2_q;

  always_comb begin
    if (b_up)      pdir = DIR_UP;
    else if (b_dn) pdir = DIR_DN;
    else if (b_lt) pdir = DIR_LT;
    else           pdir = DIR_RT;
  end

  // Target tile evaluated in signed space so a step left/up from 0 is caught, not wrapped.
  always_comb begin
    tx = $signed({2'b00, cx_q});
    ty = $signed({2'b00, cy_q});
    case (dir_q)
      DIR_UP: ty = ty - 7'sd1;
      DIR_DN: ty = ty + 7'sd1;
      DIR_LT: tx = tx - 7'sd1;
      DIR_RT: tx = tx + 7'sd1;
    endcase
    w_eff    = (maze_width  > 5'd16) ? 5'd16 : maze_width;
    h_eff    = (maze_height > 5'd16) ? 5'd16 : maze_height;
    bit_idx  = 8'({4'b0000, ty[3:0]} * 8'(MAP_W)) + {4'b0000, tx[3:0]};
    blocked  = (tx < 0) || (ty < 0) ||
               (tx >= $signed({2'b00, w_eff})) || (ty >= $signed({2'b00, h_eff})) ||
               !path_data[bit_idx];
    hit_exit = (tx[4:0] == exit_x) && (ty[4:0] == exit_y);
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    moves_d = moves_q;
    won_d   = won_q;
    sync1_d = {btn_right, btn_left, btn_down, btn_up};
    sync2_d = sync1_q;

    case (state_q)
      IDLE: begin
        if (enable && any_btn) begin
          dir_d   = pdir;
          state_d = CHECK;
        end
      end
      CHECK: begin
        cnt_d   = '0;
        state_d = HOLD;
        if (!blocked) begin
          cx_d    = tx[4:0];
          cy_d    = ty[4:0];
          moves_d = (moves_q == 16'hFFFF) ? moves_q : moves_q + 16'd1;
          if (hit_exit) begin
            won_d   = 1'b1;
            state_d = WON;
          end
        end
      end
      HOLD: begin
        if (!any_btn || !enable) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(REPEAT_TICKS - 1)) begin
          dir_d   = pdir;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WON: ;
    endcase

    if (load) begin
      cx_d    = start_x;
      cy_d    = start_y;
      moves_d = '0;
      won_d   = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign xc_d = scroll(cx_q, maze_width, view_w);
  assign yc_d = scroll(cy_q, maze_height, view_h);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      moves_q <= '0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      moves_q <= moves_d;
      won_q   <= won_d;
    end
  end

  assign char_x  = {2'b00, cx_q};
  assign char_y  = {2'b00, cy_q};
  assign x_coord = xc_q;
  assign y_coord = yc_q;
  assign moves   = moves_q;
  assign won     = won_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Self-checking bench for maze_player_ctrl: directed table, timing sequences and
// randomized presses against a press-level reference model.
module tb_maze_player_ctrl;

  localparam int RT = 4;

  logic         clk = 1'b0;
  logic         reset, enable, load;
  logic         btn_up, btn_down, btn_left, btn_right;
  logic [255:0] path_data;
  logic [4:0]   maze_width, maze_height, start_x, start_y, exit_x, exit_y, view_w, view_h;
  logic [6:0]   char_x, char_y;
  logic [4:0]   x_coord, y_coord;
  logic [15:0]  moves;
  logic         won;

  maze_player_ctrl #(.REPEAT_TICKS(RT), .MAP_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .load(load), .path_data(path_data),
    .maze_width(maze_width), .maze_height(maze_height),
    .start_x(start_x), .start_y(start_y), .exit_x(exit_x), .exit_y(exit_y),
    .view_w(view_w), .view_h(view_h),
    .char_x(char_x), .char_y(char_y), .x_coord(x_coord), .y_coord(y_coord),
    .moves(moves), .won(won)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;   // {right, left, down, up}
    int         hold;
    logic       en;
    int         ex, ey, em, ew;
  } vec_t;

  vec_t tbl[9];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // reference model state
  int mx, my, mmoves;
  bit mwon;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int ex, input int ey,
                             input int em, input int ew);
    check({name, ".char_x"}, int'(char_x), ex);
    check({name, ".char_y"}, int'(char_y), ey);
    check({name, ".moves"},  int'(moves),  em);
    check({name, ".won"},    int'(won),    ew);
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  task automatic press(input logic [3:0] m, input int h);
    set_btns(m);
    repeat (h) tick();
    set_btns(4'b0000);
    repeat (8) tick();
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    mx = int'(start_x); my = int'(start_y); mmoves = 0; mwon = 0;
  endtask

  function automatic void set_open(input int x, input int y, input logic v);
    path_data[x + 16*y] = v;
  endfunction

  function automatic bit model_open(input int x, input int y);
    int we, he;
    we = (maze_width  > 16) ? 16 : int'(maze_width);
    he = (maze_height > 16) ? 16 : int'(maze_height);
    if (x < 0 || y < 0 || x >= we || y >= he) return 0;
    return path_data[x + 16*y];
  endfunction

  function automatic int exp_scroll(input int c, input int sz, input int v);
    int se, d;
    se = (sz > 16) ? 16 : sz;
    if (se <= v) return 0;
    d = c - v / 2;
    if (d < 0) return 0;
    if (d > se - v) return se - v;
    return d;
  endfunction

  // A press held h cycles yields one attempt, plus one per further RT+1 cycles held.
  task automatic model_press(input logic [3:0] m, input int h);
    int n, dx, dy, tx, ty;
    if (!enable || mwon) return;
    n = (h - 1) / (RT + 1) + 1;
    dx = 0; dy = 0;
    if (m[0])      dy = -1;
    else if (m[1]) dy = 1;
    else if (m[2]) dx = -1;
    else           dx = 1;
    for (int k = 0; k < n; k++) begin
      tx = mx + dx; ty = my + dy;
      if (model_open(tx, ty)) begin
        mx = tx; my = ty;
        if (mmoves < 65535) mmoves++;
        if (tx == int'(exit_x) && ty == int'(exit_y)) begin
          mwon = 1;
          break;
        end
      end
    end
  endtask

  initial begin
    int ex, a;
    tbl[0] = '{4'b0001, 3, 1'b1, 1, 1, 0, 0};
    tbl[1] = '{4'b1000, 3, 1'b1, 2, 1, 1, 0};
    tbl[2] = '{4'b1000, 3, 1'b1, 3, 1, 2, 0};
    tbl[3] = '{4'b0100, 3, 1'b1, 2, 1, 3, 0};
    tbl[4] = '{4'b1001, 3, 1'b1, 2, 1, 3, 0};
    tbl[5] = '{4'b1100, 3, 1'b1, 1, 1, 4, 0};
    tbl[6] = '{4'b0010, 3, 1'b1, 1, 1, 4, 0};
    tbl[7] = '{4'b1000, 1, 1'b1, 2, 1, 5, 0};
    tbl[8] = '{4'b1000, 3, 1'b0, 2, 1, 5, 0};

    reset = 1'b1; enable = 1'b1; load = 1'b0;
    set_btns(4'b0000);
    path_data = '0;
    for (int x = 0; x <= 5; x++) set_open(x, 1, 1'b1);
    maze_width = 5'd8; maze_height = 5'd8; view_w = 5'd8; view_h = 5'd8;
    start_x = 5'd1; start_y = 5'd1; exit_x = 5'd7; exit_y = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 0);
    check("reset.x_coord", int'(x_coord), 0);
    check("reset.y_coord", int'(y_coord), 0);
    reset = 1'b0;
    tick();

    do_load();
    check_state("load", 1, 1, 0, 0);
    check("load.x_coord", int'(x_coord), 0);

    for (int i = 0; i < 9; i++) begin
      enable = tbl[i].en;
      press(tbl[i].mask, tbl[i].hold);
      check_state($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].em, tbl[i].ew);
    end
    enable = 1'b1;

    // latency: move lands on the 4th edge after the pad changes
    do_load();
    set_btns(4'b1000);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 3) set_btns(4'b0000);
      check($sformatf("latency.e%0d", e), int'(char_x), (e >= 4) ? 2 : 1);
    end
    repeat (8) tick();
    check_state("latency.final", 2, 1, 1, 0);

    // auto-repeat: attempts at edges 4, 4+(RT+1), ... ; wall at x=6
    do_load();
    set_btns(4'b1000);
    for (int e = 1; e <= 30; e++) begin
      tick();
      a = 0;
      for (int k = 0; 4 + k*(RT+1) <= e; k++) a++;
      ex = (1 + a > 5) ? 5 : 1 + a;
      check($sformatf("repeat.e%0d", e), int'(char_x), ex);
    end
    set_btns(4'b0000);
    repeat (8) tick();
    check_state("repeat.final", 5, 1, 4, 0);

    // win at (3,1), buttons then ignored, load clears
    exit_x = 5'd3; exit_y = 5'd1;
    do_load();
    press(4'b1000, 3);
    check_state("win.step1", 2, 1, 1, 0);
    set_btns(4'b1000);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 3) set_btns(4'b0000);
      check($sformatf("win.e%0d", e), int'(won), (e >= 4) ? 1 : 0);
    end
    repeat (8) tick();
    press(4'b0100, 3);
    check_state("win.ignored", 3, 1, 2, 1);
    do_load();
    check_state("win.reload", 1, 1, 0, 0);
    exit_x = 5'd1; exit_y = 5'd1;
    do_load();
    check_state("startexit.load", 1, 1, 0, 0);
    press(4'b1000, 3);
    press(4'b0100, 3);
    check_state("startexit.return", 1, 1, 2, 1);
    exit_x = 5'd7; exit_y = 5'd7;

    // left at x=0 must not wrap
    start_x = 5'd0;
    do_load();
    press(4'b0100, 3);
    check_state("nowrap", 0, 1, 0, 0);
    start_x = 5'd1;

    // scroll origin clamping and its extra cycle of latency
    path_data = '1;
    maze_width = 5'd16; maze_height = 5'd16;
    start_x = 5'd11; start_y = 5'd3; exit_x = 5'd15; exit_y = 5'd15;
    do_load();
    check("scroll.load.x", int'(x_coord), 7);
    check("scroll.load.y", int'(y_coord), 0);
    set_btns(4'b1000);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 3) set_btns(4'b0000);
      check($sformatf("scroll.e%0d", e), int'(x_coord), (e >= 5) ? 8 : 7);
    end
    repeat (8) tick();
    press(4'b1000, 3);
    check("scroll.clamp", int'(x_coord), 8);
    maze_width = 5'd20;
    start_x = 5'd5; start_y = 5'd9;
    do_load();
    check("scroll.x5", int'(x_coord), 1);
    check("scroll.y9", int'(y_coord), 5);
    view_w = 5'd16;
    tick();
    check("scroll.wideview", int'(x_coord), 0);
    view_w = 5'd8;

    // asynchronous reset while held in HOLD
    set_btns(4'b1000);
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    check_state("asyncrst", 0, 0, 0, 0);
    check("asyncrst.x_coord", int'(x_coord), 0);
    check("asyncrst.y_coord", int'(y_coord), 0);
    set_btns(4'b0000);
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    check_state("asyncrst.after", 0, 0, 0, 0);

    // randomized presses against the model
    for (int mz = 0; mz < 4; mz++) begin
      for (int b = 0; b < 256; b++) path_data[b] = ($urandom_range(0, 3) != 0);
      maze_width  = 5'($urandom_range(1, 20));
      maze_height = 5'($urandom_range(1, 20));
      view_w      = 5'($urandom_range(1, 16));
      view_h      = 5'($urandom_range(1, 16));
      start_x = 5'($urandom_range(0, ((maze_width  > 16) ? 16 : int'(maze_width))  - 1));
      start_y = 5'($urandom_range(0, ((maze_height > 16) ? 16 : int'(maze_height)) - 1));
      exit_x  = 5'($urandom_range(0, 15));
      exit_y  = 5'($urandom_range(0, 15));
      do_load();
      for (int p = 0; p < 25; p++) begin
        logic [3:0] m;
        int h;
        if ($urandom_range(0, 9) == 0) do_load();
        enable = ($urandom_range(0, 9) != 0);
        m = 4'($urandom_range(1, 15));
        h = $urandom_range(1, 14);
        model_press(m, h);
        press(m, h);
        check_state($sformatf("rnd%0d.%0d", mz, p), mx, my, mmoves, int'(mwon));
        check($sformatf("rnd%0d.%0d.x_coord", mz, p), int'(x_coord),
              exp_scroll(mx, int'(maze_width), int'(view_w)));
        check($sformatf("rnd%0d.%0d.y_coord", mz, p), int'(y_coord),
              exp_scroll(my, int'(maze_height), int'(view_h)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
